// File: rtl/line_buf_sched.sv
// Sequencer for a cascade of line FIFOs forming a video line buffer: drives the FIFO
// enables and reset, tracks column/row, flags window validity and FIFO misuse.
// Optional level check: define LINE_BUF_SCHED_LEVEL_CHK_EN.
module line_buf_sched #(
  parameter int c_LINE_WIDTH = 640,
  parameter int c_NUM_LINES  = 2,
  parameter int c_COL_WIDTH  = 10,
  parameter int c_ROW_WIDTH  = 11,
  parameter int c_RD_LAT     = 1,
  parameter int c_FLUSH_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sof,
  input  logic                     pix_vld,
  input  logic [c_NUM_LINES-1:0]   fifo_wfull,
  input  logic [c_NUM_LINES-1:0]   fifo_rempty,
  output logic [c_NUM_LINES-1:0]   fifo_w_en,
  output logic [c_NUM_LINES-1:0]   fifo_r_en,
  output logic                     fifo_rst,
  output logic [c_COL_WIDTH-1:0]   col,
  output logic [c_ROW_WIDTH-1:0]   row,
  output logic                     win_vld,
  output logic                     busy,
  output logic                     err_ovf,
  output logic                     err_udf,
  output logic                     err_drop
`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
  ,
  input  logic [c_NUM_LINES*(c_COL_WIDTH+1)-1:0] fifo_rd_level,
  output logic                                   err_lvl
`endif
);

  localparam int FW = $clog2(c_FLUSH_CYC + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;

  state_t                  state, state_nxt;
  logic [c_COL_WIDTH-1:0]  col_q;
  logic [c_ROW_WIDTH-1:0]  row_q;
  logic [FW-1:0]           flush_cnt;
  logic [c_RD_LAT-1:0]     win_pipe;
  logic                    accept;
  logic                    wrap;

  // sof always wins over a coincident pixel
  assign accept = pix_vld & ~sof & ~rst & ((state == FILL) | (state == RUN));
  assign wrap   = accept & (col_q == c_COL_WIDTH'(c_LINE_WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = IDLE;
      FLUSH: if (flush_cnt == FW'(c_FLUSH_CYC - 1)) state_nxt = FILL;
      FILL:  if (wrap && row_q == c_ROW_WIDTH'(c_NUM_LINES - 1)) state_nxt = RUN;
      RUN:   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (sof) state_nxt = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (sof) begin
        col_q     <= '0;
        row_q     <= '0;
        flush_cnt <= '0;
      end else begin
        if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
        if (accept) begin
          if (wrap) begin
            col_q <= '0;
            if (row_q != '1) row_q <= row_q + c_ROW_WIDTH'(1);
          end else begin
            col_q <= col_q + c_COL_WIDTH'(1);
          end
        end
      end
    end
  end

  // Line k is written once line k-1 holds a full row, and read once it holds one itself
  always_comb begin
    fifo_w_en = '0;
    fifo_r_en = '0;
    for (int unsigned k = 0; k < c_NUM_LINES; k++) begin
      fifo_w_en[k] = accept & ((k == 0) || (row_q >= c_ROW_WIDTH'(k)));
      fifo_r_en[k] = accept & (row_q >= c_ROW_WIDTH'(k + 1));
    end
  end

  assign fifo_rst = rst | (state == FLUSH);
  assign busy     = (state != IDLE);
  assign col      = col_q;
  assign row      = row_q;
  assign win_vld  = win_pipe[c_RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst || sof) begin
      win_pipe <= '0;
    end else begin
      win_pipe[0] <= accept & (state == RUN);
      for (int unsigned i = 1; i < c_RD_LAT; i++) win_pipe[i] <= win_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      if (|(fifo_w_en & fifo_wfull)) err_ovf <= 1'b1;
      if (|(fifo_r_en & fifo_rempty)) err_udf <= 1'b1;
      if (pix_vld && (sof || state == IDLE || state == FLUSH)) err_drop <= 1'b1;
    end
  end

`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
  localparam int LW = c_COL_WIDTH + 1;

  logic chk_pend;
  logic lvl_bad;

  always_comb begin
    lvl_bad = 1'b0;
    for (int unsigned k = 0; k < c_NUM_LINES; k++)
      if (fifo_rd_level[k*LW +: LW] != LW'(c_LINE_WIDTH)) lvl_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_pend <= 1'b0;
      err_lvl  <= 1'b0;
    end else begin
      chk_pend <= ~sof & wrap & (state == RUN);
      if (chk_pend && lvl_bad) err_lvl <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_line_buf_sched.sv
// Directed bench for line_buf_sched: pixel-count model checked every cycle,
// plus literal expectations for the planned scenarios.
module tb_line_buf_sched;
  localparam int W = 8, N = 2, CW = 10, RW = 11, LAT = 1, FL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, sof = 1'b0, pix_vld = 1'b0;
  logic [N-1:0] wfull = '0, rempty = '0;
  logic [N-1:0] w_en, r_en;
  logic f_rst, win_vld, busy, err_ovf, err_udf, err_drop;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
  logic [N*(CW+1)-1:0] lvl;
  logic err_lvl;
`endif

  int checks = 0, errors = 0;

  line_buf_sched #(.c_LINE_WIDTH(W), .c_NUM_LINES(N), .c_COL_WIDTH(CW),
                   .c_ROW_WIDTH(RW), .c_RD_LAT(LAT), .c_FLUSH_CYC(FL)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_vld(pix_vld),
    .fifo_wfull(wfull), .fifo_rempty(rempty),
    .fifo_w_en(w_en), .fifo_r_en(r_en), .fifo_rst(f_rst),
    .col(col), .row(row), .win_vld(win_vld), .busy(busy),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_drop(err_drop)
`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
    , .fifo_rd_level(lvl), .err_lvl(err_lvl)
`endif
  );

  always #5 clk = ~clk;

  // Model: frame progress is just the number of pixels accepted since sof
  bit m_valid = 0, m_active = 0, m_ovf = 0, m_udf = 0, m_drop = 0, m_lvl = 0, m_lvl_pend = 0;
  int m_flush = 0, m_n = 0;
  bit [LAT-1:0] m_pipe = '0;

  bit e_acc;
  int e_row;
  logic [N-1:0] e_wen, e_ren;

  always_comb begin
    e_acc = pix_vld && m_active && (m_flush == 0) && !sof && !rst;
    e_row = m_n / W;
    if (e_row > 2**RW - 1) e_row = 2**RW - 1;
    for (int k = 0; k < N; k++) begin
      e_wen[k] = e_acc && (e_row >= k);
      e_ren[k] = e_acc && (e_row >= k + 1);
    end
  end

  always @(posedge clk) begin
    bit win_in, new_pend;
    if (rst) begin
      m_valid = 1; m_active = 0; m_flush = 0; m_n = 0; m_pipe = '0;
      m_ovf = 0; m_udf = 0; m_drop = 0; m_lvl = 0; m_lvl_pend = 0;
    end else begin
      win_in   = e_acc && (m_n >= N*W);
      new_pend = win_in && (m_n % W == W - 1);
      if (|(e_wen & wfull)) m_ovf = 1;
      if (|(e_ren & rempty)) m_udf = 1;
      if (pix_vld && (sof || !m_active || m_flush > 0)) m_drop = 1;
`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
      if (m_lvl_pend)
        for (int k = 0; k < N; k++) if (lvl[k*(CW+1) +: CW+1] != (CW+1)'(W)) m_lvl = 1;
`endif
      if (sof) begin
        m_active = 1; m_flush = FL; m_n = 0; m_pipe = '0; m_lvl_pend = 0;
      end else begin
        if (m_flush > 0) m_flush--;
        if (e_acc) m_n++;
        m_pipe = (m_pipe << 1) | LAT'(win_in);
        m_lvl_pend = new_pend;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("w_en", w_en, e_wen);
      chk("r_en", r_en, e_ren);
      chk("fifo_rst", f_rst, rst || m_flush > 0);
      chk("col", col, m_n % W);
      chk("row", row, e_row);
      chk("win_vld", win_vld, m_pipe[LAT-1]);
      chk("busy", busy, m_active);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_udf", err_udf, m_udf);
      chk("err_drop", err_drop, m_drop);
`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
      chk("err_lvl", err_lvl, m_lvl);
`endif
    end
  end

  task automatic cyc(input bit s, input bit p, input logic [N-1:0] wf = '0,
                     input logic [N-1:0] re = '0);
    @(posedge clk); #1;
    sof = s; pix_vld = p; wfull = wf; rempty = re;
    @(negedge clk);
  endtask

  initial begin
`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
    for (int k = 0; k < N; k++) lvl[k*(CW+1) +: CW+1] = (CW+1)'(W);
`endif
    cyc(0, 0); cyc(0, 0);
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_frst", f_rst, 0);
    chk("lit_reset_row", row, 0);

    // scenario 1: flush then fill row 0
    cyc(1, 0);
    cyc(0, 0); chk("lit_flush1", f_rst, 1); chk("lit_flush_busy", busy, 1);
    cyc(0, 0); chk("lit_flush2", f_rst, 1);
    cyc(0, 0); chk("lit_flush_end", f_rst, 0);
    for (int i = 0; i < W; i++) begin
      cyc(0, 1);
      chk("lit_row0_wen", w_en, 2'b01);
      chk("lit_row0_ren", r_en, 2'b00);
    end
    cyc(0, 0); chk("lit_row0_done", row, 1);

    // scenario 2: row 1
    for (int i = 0; i < W; i++) begin
      cyc(0, 1);
      chk("lit_row1_wen", w_en, 2'b11);
      chk("lit_row1_ren", r_en, 2'b01);
      chk("lit_row1_win", win_vld, 0);
    end
    cyc(0, 0); chk("lit_row1_done", row, 2); chk("lit_row1_win_after", win_vld, 0);

    // scenario 3: row 2 with gaps
    for (int i = 0; i < W; i++) begin
      cyc(0, 1);
      chk("lit_row2_col", col, i);
      chk("lit_row2_ren", r_en, 2'b11);
      cyc(0, 0);
      chk("lit_row2_gap_ren", r_en, 2'b00);
      chk("lit_row2_win", win_vld, 1);
    end
    chk("lit_row2_noerr", {err_ovf, err_udf, err_drop}, 3'b000);

`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
    lvl[1*(CW+1) +: CW+1] = (CW+1)'(7);
`endif
    // scenario 5: FIFO flag violations in row 3
    cyc(0, 1, 2'b10, 2'b00);
    cyc(0, 1, 2'b00, 2'b01);
    cyc(0, 0); chk("lit_ovf", err_ovf, 1); chk("lit_udf", err_udf, 1);

    // scenario 4: sof mid-line at row 4 col 3 with a pixel
    for (int g = 0; g < 64 && m_n != 4*W + 3; g++) cyc(0, 1);
    chk("lit_pos_r4c3", {row, col}, {RW'(4), CW'(3)});
    cyc(1, 1);
    cyc(0, 0);
    chk("lit_sof_drop", err_drop, 1);
    chk("lit_sof_win", win_vld, 0);
    chk("lit_sof_col", col, 0);
    chk("lit_sof_row", row, 0);
    chk("lit_sof_frst", f_rst, 1);
    chk("lit_ovf_sticky", err_ovf, 1);
`ifdef LINE_BUF_SCHED_LEVEL_CHK_EN
    chk("lit_lvl", err_lvl, 1);
`endif
    cyc(0, 0); cyc(0, 0);

    // reset clears sticky errors; a pixel in IDLE is dropped
    @(posedge clk); #1; rst = 1'b1; @(negedge clk);
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    chk("lit_rst_errs", {err_ovf, err_udf, err_drop}, 3'b000);
    cyc(0, 1);
    cyc(0, 0); chk("lit_idle_drop", err_drop, 1); chk("lit_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
